light_conflict_monitor: RTL and testbench

- Receiving-end safety monitor for the four-approach traffic light controller outputs: M1, M2, MT (main turn) and S (side).
- Samples the four 3-bit light buses every clock and checks encoding, conflicting right-of-way, colour sequencing, minimum yellow time and a stuck-output watchdog.
- On any violation it latches a fault code and source approach, and drives a flash-red request until cleared.
- Sits between the controller and the lamp drivers; it never modifies the light buses itself.

---
 rtl/light_conflict_monitor.sv | 199 +++++++++++++++++++
 tb/tb_light_conflict_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - safety monitor for four-approach traffic light buses
// Checks encoding, right-of-way conflicts, colour sequencing, yellow time and a stuck-bus watchdog.
module light_conflict_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int WDT_CYCLES = 32,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       clr_fault,
    output logic       ok,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_src,
    output logic       flash
);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int WW = $clog2(WDT_CYCLES + 1);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_ENC  = 3'd1;
    localparam logic [2:0] C_CONF = 3'd2;
    localparam logic [2:0] C_SEQ  = 3'd3;
    localparam logic [2:0] C_SHY  = 3'd4;
    localparam logic [2:0] C_WDT  = 3'd5;

    typedef enum logic [1:0] {ARM, MONITOR, FAULT} state_t;

    state_t             state;
    logic [3:0][2:0]    cur;
    logic [3:0][2:0]    prev;
    logic [3:0][YW-1:0] ycnt;
    logic [WW-1:0]      wdt_cnt;
    logic [WW-1:0]      wdt_next;
    logic [FW-1:0]      flash_cnt;

    logic [3:0] enc_bad;
    logic [3:0] act;
    logic [3:0] seq_bad;
    logic [3:0] sy_bad;
    logic       s_conf;
    logic       mt_conf;
    logic       wdt_bad;
    logic [2:0] arm_code;
    logic [1:0] arm_src;
    logic [2:0] mon_code;
    logic [1:0] mon_src;

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic step_ok(input logic [2:0] a, input logic [2:0] b);
        return (a == b) ||
               (a == GREEN  && b == YELLOW) ||
               (a == YELLOW && b == RED) ||
               (a == RED    && b == GREEN);
    endfunction

    // Index 0..3 is M1, M2, MT, S, matching the fault_src numbering.
    assign cur = {light_S, light_MT, light_M2, light_M1};

    always_comb begin
        enc_bad = '0;
        act     = '0;
        seq_bad = '0;
        sy_bad  = '0;
        for (int i = 0; i < 4; i++) begin
            enc_bad[i] = !(cur[i] == GREEN || cur[i] == YELLOW || cur[i] == RED);
            act[i]     = cur[i][0] | cur[i][1];
            seq_bad[i] = !step_ok(prev[i], cur[i]);
            sy_bad[i]  = (prev[i] == YELLOW) && (cur[i] == RED) &&
                         (ycnt[i] < YW'(MIN_YELLOW));
        end

        s_conf   = act[3] & (|act[2:0]);
        mt_conf  = act[1] & act[2];
        wdt_next = (cur != prev) ? '0 : wdt_cnt + 1'b1;
        wdt_bad  = (wdt_next >= WW'(WDT_CYCLES));

        arm_code = C_NONE;
        arm_src  = 2'd0;
        if (|enc_bad) begin
            arm_code = C_ENC;
            arm_src  = low_idx(enc_bad);
        end else if (s_conf) begin
            // Every active approach clashes with S, so the lowest active one is reported.
            arm_code = C_CONF;
            arm_src  = low_idx(act);
        end else if (mt_conf) begin
            arm_code = C_CONF;
            arm_src  = 2'd1;
        end

        mon_code = arm_code;
        mon_src  = arm_src;
        if (arm_code == C_NONE) begin
            if (|seq_bad) begin
                mon_code = C_SEQ;
                mon_src  = low_idx(seq_bad);
            end else if (|sy_bad) begin
                mon_code = C_SHY;
                mon_src  = low_idx(sy_bad);
            end else if (wdt_bad) begin
                mon_code = C_WDT;
                mon_src  = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARM;
            ok         <= 1'b0;
            fault      <= 1'b0;
            fault_code <= C_NONE;
            fault_src  <= 2'd0;
            flash      <= 1'b0;
            prev       <= {4{RED}};
            ycnt       <= '0;
            wdt_cnt    <= '0;
            flash_cnt  <= '0;
        end else begin
            case (state)
                ARM: begin
                    prev    <= cur;
                    ycnt    <= '0;
                    wdt_cnt <= '0;
                    if (arm_code != C_NONE) begin
                        state      <= FAULT;
                        ok         <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= arm_code;
                        fault_src  <= arm_src;
                        flash      <= 1'b1;
                        flash_cnt  <= '0;
                    end else begin
                        state <= MONITOR;
                        ok    <= 1'b1;
                    end
                end
                MONITOR: begin
                    prev    <= cur;
                    wdt_cnt <= wdt_next;
                    for (int i = 0; i < 4; i++) begin
                        if (cur[i] == YELLOW) begin
                            if (ycnt[i] != YW'(MIN_YELLOW)) ycnt[i] <= ycnt[i] + 1'b1;
                        end else begin
                            ycnt[i] <= '0;
                        end
                    end
                    if (mon_code != C_NONE) begin
                        state      <= FAULT;
                        ok         <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= mon_code;
                        fault_src  <= mon_src;
                        flash      <= 1'b1;
                        flash_cnt  <= '0;
                    end
                end
                FAULT: begin
                    // Clearing wins over anything seen this cycle; ARM re-checks next.
                    if (clr_fault) begin
                        state      <= ARM;
                        fault      <= 1'b0;
                        fault_code <= C_NONE;
                        fault_src  <= 2'd0;
                        flash      <= 1'b0;
                        flash_cnt  <= '0;
                    end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                        flash_cnt <= '0;
                        flash     <= ~flash;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARM;
                    ok    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb/tb_light_conflict_monitor.sv - scoreboard bench for light_conflict_monitor
// Driver pushes reference-model expectations; a monitor pops and compares each cycle.
module tb_light_conflict_monitor;
    localparam int MIN_YELLOW = 3;
    localparam int WDT_CYCLES = 32;
    localparam int FLASH_HALF = 4;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] l_m1 = R;
    logic [2:0] l_m2 = R;
    logic [2:0] l_mt = R;
    logic [2:0] l_s  = R;
    logic       clr = 1'b0;
    logic       ok;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_src;
    logic       flash;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] sb_q[$];

    // Reference model state: mode 0 arm, 1 monitor, 2 fault.
    int         m_mode;
    logic [11:0] m_prev;
    int         m_run[4];
    int         m_same;
    int         m_age;
    logic       m_ok;
    logic       m_fault;
    logic [2:0] m_code;
    logic [1:0] m_src;
    logic       m_flash;

    int nom_k = 0;

    light_conflict_monitor #(
        .MIN_YELLOW(MIN_YELLOW),
        .WDT_CYCLES(WDT_CYCLES),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .light_M1(l_m1),
        .light_M2(l_m2),
        .light_MT(l_mt),
        .light_S(l_s),
        .clr_fault(clr),
        .ok(ok),
        .fault(fault),
        .fault_code(fault_code),
        .fault_src(fault_src),
        .flash(flash)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input logic [2:0] m1, input logic [2:0] m2,
                                        input logic [2:0] mt, input logic [2:0] s);
        return {s, mt, m2, m1};
    endfunction

    function automatic logic [11:0] nominal(input int k);
        int p;
        p = k % 27;
        if (p < 8)  return pat(G, G, R, R);
        if (p < 11) return pat(G, Y, R, R);
        if (p < 17) return pat(G, R, G, R);
        if (p < 20) return pat(Y, R, Y, R);
        if (p < 24) return pat(R, R, R, G);
        return pat(R, R, R, Y);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ok/fault/code/src/flash=%b required %b at %0t",
                      name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_ok = 0; m_fault = 0; m_code = 0; m_src = 0; m_flash = 0;
        m_same = 0; m_age = 0; m_prev = {4{R}};
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic [11:0] v, input bit c, output logic [7:0] e);
        int code, src, best, nsame;
        logic [2:0] a, b;
        code = 0; src = 0;
        if (m_mode == 2) begin
            if (c) begin
                m_mode = 0; m_fault = 0; m_code = 0; m_src = 0; m_flash = 0;
            end else begin
                m_age++;
                m_flash = ((m_age / FLASH_HALF) % 2) == 0;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (code == 0 && $countones(v[3*i +: 3]) != 1) begin code = 1; src = i; end
            if (code == 0) begin
                // Only {M1,M2} and {M1,MT} may share right-of-way; any pair with S or M2+MT clashes.
                best = 4;
                for (int i = 0; i < 4; i++)
                    for (int j = i + 1; j < 4; j++)
                        if ((v[3*i] | v[3*i+1]) && (v[3*j] | v[3*j+1]) &&
                            (j == 3 || (i == 1 && j == 2)) && i < best) best = i;
                if (best < 4) begin code = 2; src = best; end
            end
            nsame = (v == m_prev) ? m_same + 1 : 0;
            if (m_mode == 1 && code == 0) begin
                for (int i = 0; i < 4; i++) begin
                    a = m_prev[3*i +: 3]; b = v[3*i +: 3];
                    if (code == 0 && a != b && b != {a[1:0], a[2]}) begin code = 3; src = i; end
                end
                for (int i = 0; i < 4; i++) begin
                    a = m_prev[3*i +: 3]; b = v[3*i +: 3];
                    if (code == 0 && a == Y && b == R && m_run[i] < MIN_YELLOW) begin
                        code = 4; src = i;
                    end
                end
                if (code == 0 && nsame >= WDT_CYCLES) begin code = 5; src = 0; end
            end
            if (m_mode == 0) begin
                m_same = 0;
                for (int i = 0; i < 4; i++) m_run[i] = 0;
            end else begin
                m_same = nsame;
                for (int i = 0; i < 4; i++) m_run[i] = (v[3*i +: 3] == Y) ? m_run[i] + 1 : 0;
            end
            m_prev = v;
            if (code != 0) begin
                m_mode = 2; m_ok = 0; m_fault = 1; m_code = 3'(code); m_src = 2'(src);
                m_age = 0; m_flash = 1;
            end else begin
                m_mode = 1; m_ok = 1;
            end
        end
        e = {m_ok, m_fault, m_code, m_src, m_flash};
    endtask

    // Called at a falling edge; leaves the caller at the next falling edge.
    task automatic drive(input logic [11:0] v, input bit c);
        logic [7:0] e;
        {l_s, l_mt, l_m2, l_m1} = v;
        clr = c;
        model_step(v, c, e);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_nominal(input int n, input bit rnd_clr);
        for (int i = 0; i < n; i++) begin
            drive(nominal(nom_k), rnd_clr ? 1'($urandom_range(0, 1)) : 1'b0);
            nom_k++;
        end
    endtask

    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("cycle", {ok, fault, fault_code, fault_src, flash}, e);
        end
    end

    initial begin
        logic [11:0] v;
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", {ok, fault, fault_code, fault_src, flash}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal cycle three times; clr_fault toggled at random must be ignored.
        nom_k = 0;
        run_nominal(81, 1'b1);

        // S green during (G,G,R,R): conflict, then garbage ignored while flashing.
        run_nominal(3, 1'b0);
        drive(pat(G, G, R, G), 1'b0);
        for (int i = 0; i < 10; i++) drive(12'($urandom), 1'b0);
        drive(pat(G, G, R, R), 1'b1);
        for (int i = 0; i < 3; i++) drive(pat(G, G, R, R), 1'b0);

        // M2 green straight to red.
        drive(pat(G, R, R, R), 1'b0);
        drive(pat(G, R, R, R), 1'b0);
        drive(pat(G, G, R, R), 1'b1);
        drive(pat(G, G, R, R), 1'b0);

        // M2 yellow only two cycles.
        drive(pat(G, Y, R, R), 1'b0);
        drive(pat(G, Y, R, R), 1'b0);
        drive(pat(G, R, R, R), 1'b0);
        drive(pat(G, G, R, R), 1'b1);
        drive(pat(G, G, R, R), 1'b0);

        // Bad MT encoding coinciding with an S conflict.
        drive(pat(G, G, 3'b011, G), 1'b0);
        drive(pat(G, G, R, R), 1'b1);

        // Frozen buses trip the watchdog, then clear and resume.
        for (int i = 0; i < WDT_CYCLES + 6; i++) drive(pat(G, G, R, R), 1'b0);
        drive(pat(G, G, R, R), 1'b1);
        nom_k = 0;
        run_nominal(27, 1'b0);

        // Asynchronous reset between edges while faulted.
        nom_k = 0;
        run_nominal(2, 1'b0);
        drive(pat(G, G, R, G), 1'b0);
        for (int i = 0; i < 3; i++) drive(pat(G, G, R, G), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {ok, fault, fault_code, fault_src, flash}, 8'h00);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        nom_k = 0;
        run_nominal(27, 1'b0);

        // Randomised phase: nominal traffic with sporadic corrupted buses and clears.
        for (int i = 0; i < 500; i++) begin
            v = nominal(nom_k);
            nom_k++;
            if ($urandom_range(0, 11) == 0) v[3*$urandom_range(0, 3) +: 3] = 3'($urandom_range(0, 7));
            drive(v, $urandom_range(0, 5) == 0);
        end

        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
